rom_port_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the single-ported instruction ROM. It shares the ROM between the instruction-fetch port and the data-load port (literal/constant reads) with round-robin fairness. It drives the ROM's address, chip-select and output-enable for a fixed number of access cycles, then captures the ROM data and returns it to the winning requester as a one-cycle response pulse. It sits between the CPU front end / load path and the ROM.

---
 rtl/rom_port_arbiter.sv | 128 ++++++++++++
 tb/tb_rom_port_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// Shares the single-ported instruction ROM between the fetch port and the data-load port
// using round-robin arbitration, fixed-length ROM access and a one-cycle response pulse.
//
// state      | meaning
// IDLE       | bus released; arbitrate between pending requests
// ACCESS     | cs/oe driven with the latched address; counting down wait cycles
// RESPOND    | one-cycle rsp_valid pulse to the granted port
module rom_port_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        ireq_valid_i,
    input  logic [31:0] ireq_addr_i,
    output logic        ireq_ready_o,
    output logic        irsp_valid_o,
    output logic [63:0] irsp_data_o,
    input  logic        dreq_valid_i,
    input  logic [31:0] dreq_addr_i,
    output logic        dreq_ready_o,
    output logic        drsp_valid_o,
    output logic [63:0] drsp_data_o,
    output logic [31:0] rom_address_o,
    output logic        rom_chip_select_o,
    output logic        rom_output_enable_o,
    input  logic [63:0] rom_data_i,
    output logic        busy_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_RESPOND = 2'd2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] irsp_data_q, irsp_data_d;
    logic [63:0] drsp_data_q, drsp_data_d;
    logic        grant_i, grant_d;
    logic        win_i, win_d;

    // Data wins a conflict only when the instruction port had the previous grant.
    assign win_d = dreq_valid_i && (!ireq_valid_i || (last_grant_q == PORT_I));
    assign win_i = ireq_valid_i && !win_d;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        irsp_data_d  = irsp_data_q;
        drsp_data_d  = drsp_data_q;
        grant_i      = 1'b0;
        grant_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!reset_i && (win_i || win_d)) begin
                    grant_i      = win_i;
                    grant_d      = win_d;
                    gnt_d        = win_d ? PORT_D : PORT_I;
                    last_grant_d = win_d ? PORT_D : PORT_I;
                    addr_d       = win_d ? dreq_addr_i : ireq_addr_i;
                    cnt_d        = WAIT_LOAD;
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (gnt_q == PORT_D) begin
                        drsp_data_d = rom_data_i;
                    end else begin
                        irsp_data_d = rom_data_i;
                    end
                    state_d = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            gnt_q        <= PORT_I;
            last_grant_q <= PORT_D;
            cnt_q        <= 4'd0;
            addr_q       <= 32'd0;
            irsp_data_q  <= 64'd0;
            drsp_data_q  <= 64'd0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            irsp_data_q  <= irsp_data_d;
            drsp_data_q  <= drsp_data_d;
        end
    end

    assign ireq_ready_o        = grant_i;
    assign dreq_ready_o        = grant_d;
    assign irsp_valid_o        = (state_q == ST_RESPOND) && (gnt_q == PORT_I);
    assign drsp_valid_o        = (state_q == ST_RESPOND) && (gnt_q == PORT_D);
    assign irsp_data_o         = irsp_data_q;
    assign drsp_data_o         = drsp_data_q;
    assign rom_chip_select_o   = (state_q == ST_ACCESS);
    assign rom_output_enable_o = (state_q == ST_ACCESS);
    assign rom_address_o       = (state_q == ST_ACCESS) ? addr_q : 32'd0;
    assign busy_o              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: two instances (WAIT_CYCLES 1 and 3) checked every cycle
// against a transaction-timing model of accept/access/respond windows.
module tb_rom_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_s, iv, dv, ir, dr, irv, drv, cs, oe, bsy;
    logic [31:0] ia [2];
    logic [31:0] da [2];
    logic [31:0] ra [2];
    logic [63:0] id [2];
    logic [63:0] dd [2];
    logic [63:0] rd [2];

    function automatic logic [63:0] rom_f(input logic [31:0] a);
        case (a)
            32'h0:   return 64'h00000000D2FFFFE0;
            32'h4:   return 64'h00000000F2B55540;
            default: return 64'h0;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rom_port_arbiter #(.WAIT_CYCLES(g == 0 ? 1 : 3)) u_dut (
            .clock_i            (clk),
            .reset_i            (rst_s[g]),
            .ireq_valid_i       (iv[g]),
            .ireq_addr_i        (ia[g]),
            .ireq_ready_o       (ir[g]),
            .irsp_valid_o       (irv[g]),
            .irsp_data_o        (id[g]),
            .dreq_valid_i       (dv[g]),
            .dreq_addr_i        (da[g]),
            .dreq_ready_o       (dr[g]),
            .drsp_valid_o       (drv[g]),
            .drsp_data_o        (dd[g]),
            .rom_address_o      (ra[g]),
            .rom_chip_select_o  (cs[g]),
            .rom_output_enable_o(oe[g]),
            .rom_data_i         (rd[g]),
            .busy_o             (bsy[g])
        );
        assign rd[g] = (cs[g] && oe[g]) ? rom_f(ra[g]) : 64'bx;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: timing of the current transaction plus requester state.
    int          cyc;
    int          acc;
    int          gnt;
    int          last_g;
    logic [31:0] acc_addr;
    logic [31:0] addr_i, addr_d;
    bit          pend_i, pend_d;
    logic [63:0] exp_i, exp_d;

    task automatic chk(input int k, input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL dut%0d %s cyc %0d observed %h expected %h", k, tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        acc    = -1000;
        gnt    = 0;
        last_g = 1;
        exp_i  = 64'd0;
        exp_d  = 64'd0;
    endtask

    task automatic step(input int k, input bit rst);
        int w;
        bit in_acc, in_rsp, idle, g_i, g_d;
        w = (k == 0) ? 1 : 3;
        @(posedge clk);
        #1;
        rst_s[k] = rst;
        iv[k]    = pend_i;
        ia[k]    = addr_i;
        dv[k]    = pend_d;
        da[k]    = addr_d;
        @(negedge clk);
        if (rst) begin
            chk(k, "ireq_ready_in_reset", {63'd0, ir[k]}, 64'd0);
            chk(k, "dreq_ready_in_reset", {63'd0, dr[k]}, 64'd0);
            model_reset();
            cyc++;
            return;
        end
        in_acc = (cyc > acc) && (cyc <= acc + w);
        in_rsp = (cyc == acc + w + 1);
        idle   = (cyc > acc + w + 1);
        if (in_rsp) begin
            if (gnt == 0) exp_i = rom_f(acc_addr);
            else          exp_d = rom_f(acc_addr);
        end
        g_i = idle && pend_i && (!pend_d || last_g == 1);
        g_d = idle && pend_d && !g_i;
        chk(k, "ireq_ready", {63'd0, ir[k]}, {63'd0, g_i});
        chk(k, "dreq_ready", {63'd0, dr[k]}, {63'd0, g_d});
        chk(k, "rom_cs", {63'd0, cs[k]}, {63'd0, in_acc});
        chk(k, "rom_oe", {63'd0, oe[k]}, {63'd0, in_acc});
        chk(k, "rom_addr", {32'd0, ra[k]}, {32'd0, in_acc ? acc_addr : 32'd0});
        chk(k, "busy", {63'd0, bsy[k]}, {63'd0, in_acc || in_rsp});
        chk(k, "irsp_valid", {63'd0, irv[k]}, {63'd0, in_rsp && gnt == 0});
        chk(k, "drsp_valid", {63'd0, drv[k]}, {63'd0, in_rsp && gnt == 1});
        chk(k, "irsp_data", id[k], exp_i);
        chk(k, "drsp_data", dd[k], exp_d);
        if (g_i || g_d) begin
            acc      = cyc;
            gnt      = g_d ? 1 : 0;
            last_g   = gnt;
            acc_addr = g_d ? addr_d : addr_i;
            if (g_d) pend_d = 1'b0;
            else     pend_i = 1'b0;
        end
        cyc++;
    endtask

    task automatic run(input int k, input int n);
        repeat (n) step(k, 1'b0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 32'h0;
            1:       return 32'h4;
            2:       return 32'h100;
            default: return $urandom;
        endcase
    endfunction

    task automatic random_phase(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            if (!pend_i && $urandom_range(0, 2) == 0) begin
                pend_i = 1'b1;
                addr_i = rand_addr();
            end else if (pend_i && $urandom_range(0, 19) == 0) begin
                pend_i = 1'b0;
            end
            if (!pend_d && $urandom_range(0, 2) == 0) begin
                pend_d = 1'b1;
                addr_d = rand_addr();
            end else if (pend_d && $urandom_range(0, 19) == 0) begin
                pend_d = 1'b0;
            end
            step(k, 1'b0);
        end
        pend_i = 1'b0;
        pend_d = 1'b0;
        run(k, 8);
    endtask

    initial begin
        rst_s = 2'b11;
        iv = 2'b00;
        dv = 2'b00;
        for (int i = 0; i < 2; i++) begin
            ia[i] = 32'd0;
            da[i] = 32'd0;
        end
        cyc = 0;
        pend_i = 1'b0;
        pend_d = 1'b0;
        addr_i = 32'd0;
        addr_d = 32'd0;
        acc_addr = 32'd0;
        model_reset();
        repeat (3) @(posedge clk);

        // WAIT_CYCLES = 1 instance
        repeat (3) step(0, 1'b1);
        run(0, 2);
        pend_i = 1'b1; addr_i = 32'h0;
        run(0, 5);
        pend_i = 1'b1; addr_i = 32'h4;
        pend_d = 1'b1; addr_d = 32'h0;
        run(0, 8);
        pend_i = 1'b1; addr_i = 32'h0;
        pend_d = 1'b1; addr_d = 32'h4;
        run(0, 8);
        pend_d = 1'b1; addr_d = 32'h4;
        run(0, 4);
        pend_i = 1'b1; addr_i = 32'h100;
        run(0, 5);
        random_phase(0, 300);

        // WAIT_CYCLES = 3 instance
        repeat (3) step(1, 1'b1);
        run(1, 2);
        pend_d = 1'b1; addr_d = 32'h4;
        run(1, 8);
        pend_i = 1'b1; addr_i = 32'h0;
        run(1, 3);
        step(1, 1'b1);
        run(1, 3);
        pend_i = 1'b1; addr_i = 32'h0;
        run(1, 8);
        pend_i = 1'b1; addr_i = 32'h4;
        pend_d = 1'b1; addr_d = 32'h0;
        run(1, 14);
        pend_i = 1'b1; addr_i = 32'h100;
        run(1, 7);
        random_phase(1, 300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
